// File: rtl/xsram_bridge.sv
// xsram_bridge: req/rdy front end for an external asynchronous SRAM.
// Reads hold oe_n low for RD_WAIT+1 cycles and sample in the last one.
// Writes run setup / pulse / hold phases around a we_n low pulse.
// All SRAM strobes come straight from flops, so the pins never glitch.
module xsram_bridge #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int RD_WAIT  = 1,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wdone,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_drive,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAX_RW = (RD_WAIT  > WR_SETUP) ? RD_WAIT  : WR_SETUP;
  localparam int MAX_PH = (WR_PULSE > WR_HOLD)  ? WR_PULSE : WR_HOLD;
  localparam int MAX_CY = (MAX_RW   > MAX_PH)   ? MAX_RW   : MAX_PH;
  localparam int CNT_W  = $clog2(MAX_CY) + 1;

  // Phase lengths minus one; zero-length phases are skipped, so the
  // clamp only keeps the constants well defined.
  localparam logic [CNT_W-1:0] LD_RD = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] LD_WS = CNT_W'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] LD_WP = CNT_W'((WR_PULSE > 0) ? WR_PULSE - 1 : 0);
  localparam logic [CNT_W-1:0] LD_WH = CNT_W'((WR_HOLD  > 0) ? WR_HOLD  - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD, WR_S, WR_P, WR_H} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // rdy follows the state register only, never req.
  assign rdy = (state == IDLE);

  // Access sequencer: state, phase counter and every registered pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      wdone      <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr <= addr;
            sram_dout <= wdata;
            sram_ce_n <= 1'b0;
            if (!we) begin
              state      <= RD;
              cnt        <= LD_RD;
              sram_oe_n  <= 1'b0;
              sram_drive <= 1'b0;
            end else if (WR_SETUP > 0) begin
              state      <= WR_S;
              cnt        <= LD_WS;
              sram_drive <= 1'b1;
              sram_we_n  <= 1'b1;
            end else begin
              state      <= WR_P;
              cnt        <= LD_WP;
              sram_drive <= 1'b1;
              sram_we_n  <= 1'b0;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            rdata     <= sram_din;
            rvalid    <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_S: begin
          if (cnt == '0) begin
            state     <= WR_P;
            cnt       <= LD_WP;
            sram_we_n <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_P: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            if (WR_HOLD > 0) begin
              state <= WR_H;
              cnt   <= LD_WH;
            end else begin
              state      <= IDLE;
              wdone      <= 1'b1;
              sram_ce_n  <= 1'b1;
              sram_drive <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_H: begin
          if (cnt == '0) begin
            state      <= IDLE;
            wdone      <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_drive <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_drive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/xsram_bridge.md
Name: xsram_bridge

Overview:
Parametrised external asynchronous SRAM controller for the soft-CPU system bus. It replaces the fixed single-cycle registered SRAM strobe path with a req/rdy handshake, programmable read wait states, and a write cycle split into setup, pulse and hold phases. It sits between the address decoder/data mux and the SRAM pins. CPU-side glue converts rdy into the CPU RDY input; that glue is outside this block.

Parameters:
ADDR_W, 16, address width on both bus and SRAM sides
DATA_W, 8, data width
RD_WAIT, 1, extra read cycles with oe_n low before data is sampled (>=0)
WR_SETUP, 1, cycles of address/data valid before we_n falls (>=0)
WR_PULSE, 2, cycles we_n held low (>=1)
WR_HOLD, 1, cycles of address/data held after we_n rises (>=0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  access request; qualified by rdy
we  in  1  1=write, 0=read; sampled with req
addr  in  ADDR_W  access address; sampled on accept
wdata  in  DATA_W  write data; sampled on accept
rdy  out  1  bridge idle and able to accept; decoded from state only
rdata  out  DATA_W  read data, held until next read completes
rvalid  out  1  one-cycle pulse: rdata updated
wdone  out  1  one-cycle pulse: write finished
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  DATA_W  data to SRAM pins
sram_din  in  DATA_W  data from SRAM pins
sram_drive  out  1  tristate enable for sram_dout (1=drive)
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset is synchronous, active-high, one edge. Effects: state=IDLE, rdy=1, rvalid=0, wdone=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_drive=0, sram_addr=0, sram_dout=0, rdata=0.
- Reset during any access aborts it at the next edge. No rvalid/wdone pulse for the aborted access. Strobes go inactive on that edge.
- States: IDLE, RD, WR_S, WR_P, WR_H. rdy=1 only in IDLE. Not combinationally dependent on req.
- Accept: clock edge where state==IDLE && req. Call that cycle N. addr, wdata and we are registered into sram_addr/sram_dout on that edge. They stay constant until the access ends.
- Read: IDLE->RD. In cycles N+1..N+1+RD_WAIT: ce_n=0, oe_n=0, drive=0. A down-counter loaded with RD_WAIT decrements per cycle. In the last RD cycle (counter==0), sram_din is registered into rdata and state returns to IDLE. rvalid=1 during cycle N+2+RD_WAIT only.
- Write phases:
  - IDLE->WR_S if WR_SETUP>0, else ->WR_P.
  - WR_S: WR_SETUP cycles, ce_n=0, we_n=1, drive=1.
  - WR_P: WR_PULSE cycles, we_n=0.
  - WR_H: WR_HOLD cycles, we_n=1, drive=1. Skipped if WR_HOLD=0.
  - Then IDLE. wdone=1 in the first IDLE cycle.
  - Total busy cycles T=WR_SETUP+WR_PULSE+WR_HOLD. wdone is high in cycle N+1+T.
- In IDLE: ce_n=oe_n=we_n=1 and drive=0.
- Invariant: oe_n=0 and drive=1 never occur in the same cycle.
- Invariant: we_n=0 and oe_n=0 never occur in the same cycle.
- Back-to-back: a new accept is allowed in the same cycle as rvalid/wdone, because state is IDLE. This gives exactly one idle bus-turnaround cycle between any two accesses.
- req while rdy=0 is ignored. The requester must hold req/addr/we/wdata until the accept edge.
- rdata is unchanged by writes and aborted reads.
- Counter width: clog2 of the largest of RD_WAIT, WR_SETUP, WR_PULSE and WR_HOLD, plus 1. Phase counters load value−1 on entry.

Test Plan:
- Reset: hold reset 2 cycles mid-write (in WR_P) -> next cycle we_n=1, ce_n=1, drive=0, rdy=1, no wdone; sram_addr=0.
- Read, RD_WAIT=1: accept addr=16'h0123 at N, SRAM model returns 8'hA5 -> oe_n low N+1..N+2, rvalid only at N+3, rdata=8'hA5, rdy low N+1..N+2.
- Write, defaults (1/2/1): accept addr=16'h4000, wdata=8'h3C at N -> we_n low exactly N+2..N+3, drive high N+1..N+4, wdone at N+5, SRAM model holds 8'h3C.
- Back-to-back write then read of the same address -> read accepted in the wdone cycle; oe_n falls one cycle after drive falls; rdata=written value.
- RD_WAIT=0, WR_SETUP=0, WR_HOLD=0 build -> read rvalid at N+2; write we_n low N+1..N+WR_PULSE; invariants hold.
- req held while busy with a changing addr -> only the addr at the accept edge reaches sram_addr; the second access starts only after rdy returns.
